// File: rtl/philv_pkg.sv
// Shared encodings for the PhilosophyV control/execute slice: opcodes,
// ALU op codes, source-B select codes and the FSM state encoding.
package philv_pkg;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_funct_t;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_STEP = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;
    localparam logic [1:0] SRC_B_ZERO = 2'b11;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'b00,
        ST_DECODE    = 2'b01,
        ST_EXECUTE   = 2'b10,
        ST_WRITEBACK = 2'b11
    } state_t;

    // sub_en / sra_en say whether instr[30] may turn ADD into SUB / SRL into SRA
    function automatic alu_funct_t decode_funct(input logic [2:0] funct3,
                                                input logic       sub_en,
                                                input logic       sra_en);
        alu_funct_t f;
        case (funct3)
            3'b000:  f = sub_en ? ALU_SUB : ALU_ADD;
            3'b001:  f = ALU_SLL;
            3'b010:  f = ALU_SLT;
            3'b011:  f = ALU_SLTU;
            3'b100:  f = ALU_XOR;
            3'b101:  f = sra_en ? ALU_SRA : ALU_SRL;
            3'b110:  f = ALU_OR;
            default: f = ALU_AND;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/philv_alu_unit.sv
// Combinational RV32I ALU: z = funct(x, y); unused op codes yield zero.
module philv_alu_unit
    import philv_pkg::*;
#(
    parameter int BUS_WIDTH = 32
) (
    input  logic [3:0]           funct,
    input  logic [BUS_WIDTH-1:0] x,
    input  logic [BUS_WIDTH-1:0] y,
    output logic [BUS_WIDTH-1:0] z
);

    localparam int SH_W = $clog2(BUS_WIDTH);

    logic [SH_W-1:0] shamt;
    logic            lt_s;
    logic            lt_u;

    assign shamt = y[SH_W-1:0];
    assign lt_s  = $signed(x) < $signed(y);
    assign lt_u  = x < y;

    always_comb begin
        z = '0;
        case (funct)
            ALU_ADD:  z = x + y;
            ALU_SUB:  z = x - y;
            ALU_SLL:  z = x << shamt;
            ALU_SLT:  z = {{(BUS_WIDTH-1){1'b0}}, lt_s};
            ALU_SLTU: z = {{(BUS_WIDTH-1){1'b0}}, lt_u};
            ALU_XOR:  z = x ^ y;
            ALU_SRL:  z = x >> shamt;
            ALU_SRA:  z = $unsigned($signed(x) >>> shamt);
            ALU_OR:   z = x | y;
            ALU_AND:  z = x & y;
            default:  z = '0;
        endcase
    end

endmodule

// File: rtl/philv_exec_ctrl.sv
// Main controller FSM, ALU decoder and ALU with registered result for the
// PhilosophyV multicycle core. Optional macro PHILV_ALU_ZERO_FLAG_EN adds alu_zero/zero_q.
//
// state      | meaning
// -----------+---------------------------------------------------------
// FETCH      | alu_result = pc + PC_STEP, PC loads it
// DECODE     | operand registers settle, no enables
// EXECUTE    | ALU runs the decoded op on rs1 and rs2/immediate
// WRITEBACK  | register file captures alu_out (R/I-type only)
module philv_exec_ctrl
    import philv_pkg::*;
#(
    parameter int BUS_WIDTH = 32,
    parameter int PC_STEP   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr,
    input  logic [BUS_WIDTH-1:0] pc,
    input  logic [BUS_WIDTH-1:0] rs1_data,
    input  logic [BUS_WIDTH-1:0] rs2_data,
    output logic                 pc_write,
    output logic                 reg_wr_ena,
    output logic [1:0]           alu_src_b_sel,
    output logic [3:0]           alu_funct,
    output logic [BUS_WIDTH-1:0] alu_result,
    output logic [BUS_WIDTH-1:0] alu_out,
    output logic [1:0]           state
`ifdef PHILV_ALU_ZERO_FLAG_EN
    ,
    output logic                 alu_zero,
    output logic                 zero_q
`endif
);

    state_t                 state_q;
    state_t                 state_d;
    alu_funct_t             funct_sel;
    alu_funct_t             exec_funct;
    logic [1:0]             exec_b_sel;
    logic                   use_pc;
    logic                   is_r;
    logic                   is_i;
    logic [BUS_WIDTH-1:0]   imm_i;
    logic [BUS_WIDTH-1:0]   op_a;
    logic [BUS_WIDTH-1:0]   op_b;
    logic                   unused_rd;

    // rd is consumed by the register file, not here
    assign unused_rd = ^instr[11:7];

    assign is_r  = (instr[6:0] == OP_R);
    assign is_i  = (instr[6:0] == OP_I);
    assign imm_i = {{(BUS_WIDTH-12){instr[31]}}, instr[31:20]};

    // For I-type, instr[30] is immediate data except on the SRAI/SRLI pair
    always_comb begin
        exec_funct = ALU_ADD;
        exec_b_sel = SRC_B_RS2;
        if (is_r) begin
            exec_funct = decode_funct(instr[14:12], instr[30], instr[30]);
        end else if (is_i) begin
            exec_funct = decode_funct(instr[14:12], 1'b0, instr[30]);
            exec_b_sel = SRC_B_IMM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = ST_FETCH;
        pc_write      = 1'b0;
        reg_wr_ena    = 1'b0;
        use_pc        = 1'b0;
        alu_src_b_sel = SRC_B_RS2;
        funct_sel     = ALU_ADD;
        case (state_q)
            ST_FETCH: begin
                state_d       = ST_DECODE;
                pc_write      = 1'b1;
                use_pc        = 1'b1;
                alu_src_b_sel = SRC_B_STEP;
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                state_d       = ST_WRITEBACK;
                alu_src_b_sel = exec_b_sel;
                funct_sel     = exec_funct;
            end
            ST_WRITEBACK: begin
                state_d       = ST_FETCH;
                reg_wr_ena    = is_r | is_i;
                alu_src_b_sel = exec_b_sel;
                funct_sel     = exec_funct;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        op_b = '0;
        case (alu_src_b_sel)
            SRC_B_RS2:  op_b = rs2_data;
            SRC_B_STEP: op_b = BUS_WIDTH'(PC_STEP);
            SRC_B_IMM:  op_b = imm_i;
            SRC_B_ZERO: op_b = '0;
            default:    op_b = '0;
        endcase
    end

    assign op_a      = use_pc ? pc : rs1_data;
    assign alu_funct = funct_sel;
    assign state     = state_q;

    philv_alu_unit #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_alu (
        .funct (alu_funct),
        .x     (op_a),
        .y     (op_b),
        .z     (alu_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out <= '0;
        end else begin
            alu_out <= alu_result;
        end
    end

`ifdef PHILV_ALU_ZERO_FLAG_EN
    assign alu_zero = (alu_result == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b1;
        end else begin
            zero_q <= alu_zero;
        end
    end
`endif

endmodule

// File: tb/tb_philv_exec_ctrl.sv
// Scoreboard bench for philv_exec_ctrl: expected per-stage values are queued
// when an instruction is driven and popped as each FSM stage is observed.
module tb_philv_exec_ctrl;
    import philv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        pc_write;
    logic        reg_wr_ena;
    logic [1:0]  alu_src_b_sel;
    logic [3:0]  alu_funct;
    logic [31:0] alu_result;
    logic [31:0] alu_out;
    logic [1:0]  state;
`ifdef PHILV_ALU_ZERO_FLAG_EN
    logic        alu_zero;
    logic        zero_q;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];

    always #5 clk = ~clk;

    philv_exec_ctrl #(
        .BUS_WIDTH (32),
        .PC_STEP   (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .pc            (pc),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .pc_write      (pc_write),
        .reg_wr_ena    (reg_wr_ena),
        .alu_src_b_sel (alu_src_b_sel),
        .alu_funct     (alu_funct),
        .alu_result    (alu_result),
        .alu_out       (alu_out),
        .state         (state)
`ifdef PHILV_ALU_ZERO_FLAG_EN
        ,
        .alu_zero      (alu_zero),
        .zero_q        (zero_q)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        sb_entry_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", obs, 32'hDEAD_BEEF);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.exp);
        end
    endtask

    function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic [31:0] mk_i(input logic [11:0] imm, input logic [2:0] f3);
        return {imm, 5'd1, f3, 5'd4, 7'b0010011};
    endfunction

    function automatic logic [3:0] ref_funct(input logic [2:0] f3, input logic b30);
        case (f3)
            3'd0:    return b30 ? 4'd1 : 4'd0;
            3'd1:    return 4'd2;
            3'd2:    return 4'd3;
            3'd3:    return 4'd4;
            3'd4:    return 4'd5;
            3'd5:    return b30 ? 4'd7 : 4'd6;
            3'd6:    return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    function automatic logic [31:0] ref_r(input logic [2:0] f3, input logic b30,
                                          input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        case (f3)
            3'd0:    return b30 ? a + ~b + 32'd1 : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return (sa < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return b30 ? 32'(sa >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // Called at a negedge while the DUT is in FETCH; returns at the next FETCH negedge.
    task automatic run_instr(input string name, input logic [31:0] ins,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] pcv,
                             input logic [3:0] e_funct, input logic [1:0] e_bsel,
                             input logic [31:0] e_res, input logic e_wr);
        instr = ins; rs1_data = a; rs2_data = b; pc = pcv;
        sb_push({name, ".F.state"}, 32'd0);
        sb_push({name, ".F.pc_write"}, 32'd1);
        sb_push({name, ".F.reg_wr"}, 32'd0);
        sb_push({name, ".F.bsel"}, 32'd1);
        sb_push({name, ".F.result"}, pcv + 32'd4);
        sb_push({name, ".D.state"}, 32'd1);
        sb_push({name, ".D.enables"}, 32'd0);
        sb_push({name, ".D.result"}, a + b);
        sb_push({name, ".E.state"}, 32'd2);
        sb_push({name, ".E.funct"}, 32'(e_funct));
        sb_push({name, ".E.bsel"}, 32'(e_bsel));
        sb_push({name, ".E.result"}, e_res);
        sb_push({name, ".E.reg_wr"}, 32'd0);
`ifdef PHILV_ALU_ZERO_FLAG_EN
        sb_push({name, ".E.alu_zero"}, 32'(e_res == 32'd0));
        sb_push({name, ".E.zero_q"}, 32'(a + b == 32'd0));
`endif
        sb_push({name, ".W.state"}, 32'd3);
        sb_push({name, ".W.reg_wr"}, 32'(e_wr));
        sb_push({name, ".W.pc_write"}, 32'd0);
        sb_push({name, ".W.alu_out"}, e_res);
`ifdef PHILV_ALU_ZERO_FLAG_EN
        sb_push({name, ".W.zero_q"}, 32'(e_res == 32'd0));
`endif
        #1;
        sb_check(32'(state)); sb_check(32'(pc_write)); sb_check(32'(reg_wr_ena));
        sb_check(32'(alu_src_b_sel)); sb_check(alu_result);
        @(negedge clk); #1;
        sb_check(32'(state)); sb_check(32'({pc_write, reg_wr_ena})); sb_check(alu_result);
        @(negedge clk); #1;
        sb_check(32'(state)); sb_check(32'(alu_funct)); sb_check(32'(alu_src_b_sel));
        sb_check(alu_result); sb_check(32'(reg_wr_ena));
`ifdef PHILV_ALU_ZERO_FLAG_EN
        sb_check(32'(alu_zero)); sb_check(32'(zero_q));
`endif
        @(negedge clk); #1;
        sb_check(32'(state)); sb_check(32'(reg_wr_ena)); sb_check(32'(pc_write)); sb_check(alu_out);
`ifdef PHILV_ALU_ZERO_FLAG_EN
        sb_check(32'(zero_q));
`endif
        @(negedge clk);
    endtask

    initial begin
        logic [2:0]  f3;
        logic        b30;
        logic [31:0] ra;
        logic [31:0] rb;

        // reset held: FETCH decode visible, alu_out cleared
        pc = 32'h0000_0100;
        @(negedge clk); @(negedge clk); #1;
        sb_push("rst.state", 32'd0);
        sb_push("rst.alu_out", 32'd0);
        sb_push("rst.pc_write", 32'd1);
        sb_push("rst.reg_wr", 32'd0);
        sb_push("rst.result", 32'h0000_0104);
        sb_check(32'(state)); sb_check(alu_out); sb_check(32'(pc_write));
        sb_check(32'(reg_wr_ena)); sb_check(alu_result);
        @(negedge clk);
        rst = 1'b0;

        run_instr("sub",  32'h4020_81B3, 32'd10, 32'd3, 32'h100, 4'd1, 2'b00, 32'd7, 1'b1);
        run_instr("addi", 32'hFFF0_0093, 32'd5, 32'd9, 32'h104, 4'd0, 2'b10, 32'd4, 1'b1);
        run_instr("slt",  mk_r(7'h00, 3'b010), 32'h8000_0000, 32'd1, 32'h108, 4'd3, 2'b00, 32'd1, 1'b1);
        run_instr("sltu", mk_r(7'h00, 3'b011), 32'h8000_0000, 32'd1, 32'h10C, 4'd4, 2'b00, 32'd0, 1'b1);
        run_instr("sra",  mk_r(7'h20, 3'b101), 32'h8000_0000, 32'd4, 32'h110, 4'd7, 2'b00, 32'hF800_0000, 1'b1);
        run_instr("srl",  mk_r(7'h00, 3'b101), 32'h8000_0000, 32'd4, 32'h114, 4'd6, 2'b00, 32'h0800_0000, 1'b1);
        run_instr("srai", mk_i(12'h404, 3'b101), 32'h8000_0000, 32'd0, 32'h118, 4'd7, 2'b10, 32'hF800_0000, 1'b1);
        run_instr("srli", mk_i(12'h004, 3'b101), 32'h8000_0000, 32'd0, 32'h11C, 4'd6, 2'b10, 32'h0800_0000, 1'b1);
        run_instr("and0", mk_r(7'h00, 3'b111), 32'h0000_00F0, 32'h0000_000F, 32'h120, 4'd9, 2'b00, 32'd0, 1'b1);
        run_instr("illeg", {7'h20, 5'd2, 5'd1, 3'b100, 5'd3, 7'b0000000}, 32'd20, 32'd22,
                  32'hFFFF_FFFC, 4'd0, 2'b00, 32'd42, 1'b0);

        for (int i = 0; i < 8; i++) begin
            f3  = 3'($urandom_range(0, 7));
            b30 = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            if (i == 0) f3 = 3'b000;
            if (i == 1) f3 = 3'b001;
            run_instr("rnd", mk_r(b30 ? 7'h20 : 7'h00, f3), ra, rb, 32'h200 + 32'(i * 4),
                      ref_funct(f3, b30), 2'b00, ref_r(f3, b30, ra, rb), 1'b1);
        end

        // reset asserted during EXECUTE
        instr = mk_r(7'h00, 3'b110); rs1_data = 32'h0000_1234; rs2_data = 32'h0000_4321; pc = 32'h300;
        @(negedge clk); @(negedge clk); #1;
        sb_push("mid.exec_state", 32'd2);
        sb_check(32'(state));
        rst = 1'b1; #1;
        sb_push("mid.state", 32'd0);
        sb_push("mid.alu_out", 32'd0);
        sb_push("mid.pc_write", 32'd1);
        sb_push("mid.reg_wr", 32'd0);
        sb_check(32'(state)); sb_check(alu_out); sb_check(32'(pc_write)); sb_check(32'(reg_wr_ena));
        @(negedge clk); #1;
        sb_push("mid.hold_state", 32'd0);
        sb_push("mid.hold_reg_wr", 32'd0);
        sb_check(32'(state)); sb_check(32'(reg_wr_ena));
        rst = 1'b0;
        run_instr("post", mk_r(7'h00, 3'b110), 32'h0000_1234, 32'h0000_4321, 32'h300,
                  4'd8, 2'b00, 32'h0000_5335, 1'b1);

        if (sb.size() != 0) begin
            chk("sb_leftover", 32'(sb.size()), 32'd0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/philv_exec_ctrl.md
Name: philv_exec_ctrl

Overview:
- Control-plus-execute slice of the PhilosophyV multicycle RV32I core.
- Merges three functions:
  - main-controller FSM: sequences FETCH/DECODE/EXECUTE/WRITEBACK;
  - ALU decoder: maps funct3/funct7 to an ALU op;
  - ALU: combinational datapath with operand muxes and a registered result (ALU_OUT).
- Sits between the instruction/register-file-output registers and the PC/register-file write ports.

Parameters:
- BUS_WIDTH, 32, datapath width. Shift amount uses the low $clog2(BUS_WIDTH) bits of operand B.
- PC_STEP, 4, constant presented on ALU source-B select 01.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- instr  in  32  current instruction register contents
- pc  in  BUS_WIDTH  current program count
- rs1_data  in  BUS_WIDTH  registered register-file read 0
- rs2_data  in  BUS_WIDTH  registered register-file read 1
- pc_write  out  1  PC register enable; PC loads alu_result
- reg_wr_ena  out  1  register-file write enable; write data = alu_out, address = instr[11:7]
- alu_src_b_sel  out  2  00 rs2, 01 PC_STEP, 10 I-immediate, 11 zero
- alu_funct  out  4  current ALU op
- alu_result  out  BUS_WIDTH  combinational ALU output
- alu_out  out  BUS_WIDTH  ALU result registered every cycle
- state  out  2  FSM state: 00 FETCH, 01 DECODE, 10 EXECUTE, 11 WRITEBACK

Behaviour:
- Reset (async, rst=1):
  - state = FETCH, alu_out = 0.
  - Outputs reflect FETCH decode immediately, including while reset is held.
- FSM sequence is FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH, one cycle each, unconditional.
- FETCH:
  - A = pc, B sel = 01, funct = ADD, pc_write = 1, reg_wr_ena = 0.
  - alu_result = pc + PC_STEP.
- DECODE: no enables asserted; A = rs1_data, B sel = 00, funct = ADD.
- EXECUTE: A = rs1_data. B sel and funct depend on opcode instr[6:0]:
  - 0110011 (R-type): B sel = 00, funct from funct3/funct7.
  - 0010011 (I-type): B sel = 10, funct from funct3; funct7 bit 30 is honoured only for funct3 = 101 (SRAI vs SRLI), and ADDI never becomes SUB.
  - Any other opcode: B sel = 00, funct = ADD, and the instruction is treated as a NOP.
- WRITEBACK: reg_wr_ena = 1 only for R-type or I-type opcodes. Same A/B/funct selection as EXECUTE.
- alu_out <= alu_result on every rising clk edge. The value written in WRITEBACK is therefore the EXECUTE-cycle result.
- I-immediate = sign-extended instr[31:20].
- ALU funct encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND. Codes 10-15 produce 0.
- R-type decode:
  - funct3 000 → ADD, or SUB if instr[30] = 1.
  - 001 → SLL, 010 → SLT, 011 → SLTU, 100 → XOR.
  - 101 → SRL, or SRA if instr[30] = 1.
  - 110 → OR, 111 → AND.
  - Other funct7 bits are ignored.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^BUS_WIDTH.
  - SLT is a signed compare, SLTU unsigned; both return 1 or 0.
  - SRA replicates the sign bit.
- Rd = x0 is not filtered here; the register file ignores writes to x0.
- rst asserted mid-instruction: returns to FETCH at once and clears alu_out. No write is issued in that cycle unless WRITEBACK is re-entered.

Optional Feature:
- Macro: PHILV_ALU_ZERO_FLAG_EN.
- Defined: adds output port alu_zero (1 bit) = (alu_result == 0), combinational. Also adds a registered zero_q that updates together with alu_out and resets to 1.
- Undefined: neither port exists and no logic is generated.

Decomposition:
- Package philv_pkg holds:
  - opcode constants (OP_R = 7'b0110011, OP_I = 7'b0010011);
  - alu_funct_t enum (4-bit codes above);
  - src-B select codes;
  - state_t encoding.
- Natural sub-module: philv_alu_unit, a pure combinational ALU with inputs funct, x, y and output z. The FSM and decoder live in the top module.

Test Plan:
- Reset: rst pulse → state = 00, alu_out = 0, pc_write = 1; with pc = 0x100, alu_result = 0x104 in FETCH.
- Decoding a SUB: instr = SUB x3,x1,x2 (0x402081B3), rs1 = 10, rs2 = 3 → EXECUTE funct = 1, alu_result = 7; WRITEBACK reg_wr_ena = 1, alu_out = 7.
- ADDI (instr[30] set in the immediate), sign-extended: ADDI with imm = -1 (0xFFF00093), rs1 = 5 → B sel = 10, result = 4; instr[30] = 1 does not select SUB.
- Signed vs unsigned ops: rs1 = 0x80000000, rs2 = 1 → SLT = 1, SLTU = 0; SRA by 4 = 0xF8000000, SRL by 4 = 0x08000000.
- Illegal opcode and reset mid-instruction: opcode 0000000 → no reg_wr_ena in WRITEBACK; rst asserted during EXECUTE → immediate FETCH, alu_out = 0.
- Zero flag, with PHILV_ALU_ZERO_FLAG_EN defined: AND of 0xF0 and 0x0F → alu_zero = 1, zero_q = 1 on the next cycle.
